mul_unit: RTL and testbench

Parametrised iterative integer multiplier for the execute stage. It supersedes the fixed two-cycle 64-bit multiplier wrapper. Supports the full RV64M multiply set: MUL, MULH, MULHSU, MULHU and MULW. Operands are accepted through a valid/ready handshake, multiplied as unsigned magnitudes over a configurable number of radix-2^BPC iterations, sign-corrected, and held in an output register until the pipeline takes the result.

---
 rtl/mul_unit_if.sv | 39 +++
 rtl/mul_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mul_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_if.sv
// Request/response bundle for the iterative multiplier: operand handshake,
// flush and result handshake. Clock and reset stay outside the bundle.
interface mul_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] c;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  c
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output c
    );
endinterface

// File: rtl/mul_unit.sv
// Iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW), BPC bits per cycle.
// Optional MUL_UNIT_EARLY_EXIT_EN: leave BUSY once the remaining multiplier is zero.
module mul_unit #(
    parameter int XLEN = 64,
    parameter int BPC  = 8
) (
    input  logic     clk,
    input  logic     reset,
    mul_unit_if.slave bus
);
    localparam int HALF   = XLEN / 2;
    localparam int PW     = 2 * XLEN;
    localparam int N_FULL = XLEN / BPC;
    localparam int N_WORD = XLEN / (2 * BPC);
    localparam int CNT_W  = $clog2(N_FULL + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [2:0]       op_reg;
    logic             neg_reg;
    logic [PW-1:0]    mcand_reg;
    logic [XLEN-1:0]  mplier_reg;
    logic [PW-1:0]    acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  c_reg;
    logic             out_valid_reg;

    logic accept;
    logic step;
    logic last_step;

    // ------------------------------------------------------------------
    // Operand decode: signedness per op, word ops use the low half.
    // ------------------------------------------------------------------
    logic            a_signed;
    logic            b_signed;
    logic            op_legal;
    logic            op_word;
    logic [XLEN-1:0] a_src;
    logic [XLEN-1:0] b_src;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        op_legal = 1'b1;
        op_word  = 1'b0;
        case (bus.op)
            OP_MUL, OP_MULH: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            OP_MULHU:  a_signed = 1'b0;
            OP_MULW: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                op_word  = 1'b1;
            end
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        if (op_word) begin
            a_src = {{HALF{bus.a[HALF-1]}}, bus.a[HALF-1:0]};
            b_src = {{HALF{bus.b[HALF-1]}}, bus.b[HALF-1:0]};
        end else begin
            a_src = bus.a;
            b_src = bus.b;
        end
        a_neg = a_signed & a_src[XLEN-1];
        b_neg = b_signed & b_src[XLEN-1];
        a_mag = a_neg ? (~a_src + XLEN'(1)) : a_src;
        b_mag = b_neg ? (~b_src + XLEN'(1)) : b_src;
    end

    // ------------------------------------------------------------------
    // One radix-2^BPC digit: mcand is pre-shifted, so each gated row only
    // needs a small fixed shift.
    // ------------------------------------------------------------------
    logic [PW-1:0] pp_term [BPC];
    logic [PW-1:0] pp_sum;

    for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
        assign pp_term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < BPC; i++) begin
            pp_sum = pp_sum + pp_term[i];
        end
    end

    logic [PW-1:0]   acc_sum;
    logic [XLEN-1:0] mplier_shr;
    logic [PW-1:0]   product;
    logic [XLEN-1:0] result;

    assign acc_sum    = acc_reg + pp_sum;
    assign mplier_shr = mplier_reg >> BPC;
    assign product    = neg_reg ? (~acc_sum + PW'(1)) : acc_sum;

    always_comb begin
        case (op_reg)
            OP_MUL:                      result = product[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = product[PW-1:XLEN];
            OP_MULW:                     result = {{HALF{product[HALF-1]}}, product[HALF-1:0]};
            default:                     result = '0;
        endcase
    end

`ifdef MUL_UNIT_EARLY_EXIT_EN
    assign last_step = (cnt_reg == CNT_W'(1)) || (mplier_shr == '0);
`else
    assign last_step = (cnt_reg == CNT_W'(1));
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = op_legal ? BUSY : DONE;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush beats both accept and the result handshake.
        if (bus.flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            step       = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg        <= '0;
            neg_reg       <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            c_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= (state_next == DONE);
            if (accept) begin
                op_reg     <= bus.op;
                neg_reg    <= a_neg ^ b_neg;
                mcand_reg  <= {{XLEN{1'b0}}, a_mag};
                mplier_reg <= b_mag;
                acc_reg    <= '0;
                cnt_reg    <= op_word ? CNT_W'(N_WORD) : CNT_W'(N_FULL);
                if (!op_legal) begin
                    c_reg <= '0;
                end
            end else if (step) begin
                acc_reg    <= acc_sum;
                mcand_reg  <= mcand_reg << BPC;
                mplier_reg <= mplier_shr;
                cnt_reg    <= cnt_reg - CNT_W'(1);
                if (last_step) begin
                    c_reg <= result;
                end
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.c         = c_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Directed plus randomized checks of mul_unit against a full-width arithmetic
// reference; latency expectations follow MUL_UNIT_EARLY_EXIT_EN when defined.
module tb_mul_unit;
    localparam int XLEN   = 64;
    localparam int BPC    = 8;
    localparam int N_FULL = XLEN / BPC;
    localparam int N_WORD = XLEN / (2 * BPC);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_unit_if #(.XLEN(XLEN)) bus ();

    mul_unit #(.XLEN(XLEN), .BPC(BPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Reference result: exact 128-bit two's-complement products.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        logic [31:0]  w;
        logic [63:0]  r;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        w  = a[31:0] * b[31:0];
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[63:0];   end
            3'd1: begin p = sa * sb; r = p[127:64]; end
            3'd2: begin p = sa * ub; r = p[127:64]; end
            3'd3: begin p = ua * ub; r = p[127:64]; end
            3'd4: r = {{32{w[31]}}, w};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycles from the accept edge (counted as 1) to the first cycle with out_valid.
    function automatic int ref_latency(input logic [2:0] op,
                                       input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        int steps;
        if (op > 3'd4) return 1;
`ifdef MUL_UNIT_EARLY_EXIT_EN
        case (op)
            3'd0, 3'd1: m = b[63] ? (~b + 64'd1) : b;
            3'd2, 3'd3: m = b;
            default:    m = {32'd0, (b[31] ? (~b[31:0] + 32'd1) : b[31:0])};
        endcase
        steps = 1;
        while (steps < 8 && (m >> (8 * steps)) != 64'd0) steps++;
        if (a === 64'hx) steps = 0;
        return steps + 1;
`else
        steps = (op == 3'd4) ? N_WORD : N_FULL;
        if (a === 64'hx) steps = 0;
        return steps + 1;
`endif
    endfunction

    function automatic logic [63:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 255));
            4: return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input int stall, output logic [63:0] obs_c);
        int lat;
        int exp_lat;
        logic [63:0] exp_c;
        exp_c   = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        check(tag, "in_ready_pre", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check(tag, "latency", 64'(lat), 64'(exp_lat));
        check(tag, "c", bus.c, exp_c);
        obs_c = bus.c;
        // Result must hold while new requests are pending and out_ready is low.
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = 3'($urandom_range(0, 4));
            bus.a        = {$urandom, $urandom};
            bus.b        = {$urandom, $urandom};
            @(posedge clk); #1;
            check(tag, "hold_c", bus.c, exp_c);
            check(tag, "hold_valid", 64'(bus.out_valid), 64'd1);
            check(tag, "hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check(tag, "post_valid", 64'(bus.out_valid), 64'd0);
        check(tag, "post_in_ready", 64'(bus.in_ready), 64'd1);
        $display("TXN %s op=%0d a=%h b=%h c=%h lat=%0d", tag, op, a, b, obs_c, lat);
    endtask

    initial begin
        logic [63:0] obs;
        logic        saw_valid;
        int          r;
        logic [2:0]  rop;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "in_ready", 64'(bus.in_ready), 64'd1);
        check("reset", "out_valid", 64'(bus.out_valid), 64'd0);
        check("reset", "c", bus.c, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset", "in_ready_after", 64'(bus.in_ready), 64'd1);

        run_op("mul_neg", 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2, obs);
        check("mul_neg", "c_plan", obs, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mulh_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, obs);
        check("mulh_min", "c_plan", obs, 64'h4000_0000_0000_0000);
        run_op("mulhu_ones", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, obs);
        check("mulhu_ones", "c_plan", obs, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhsu_m1", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, obs);
        check("mulhsu_m1", "c_plan", obs, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulw", 3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2, 0, obs);
        check("mulw", "c_plan", obs, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op("backpressure", 3'd0, 64'd123456789, 64'hFEDC_BA98_7654_3210, 10, obs);
        run_op("after_bp", 3'd1, 64'hDEAD_BEEF_0123_4567, 64'h8765_4321_0F0F_F0F0, 0, obs);

        // Flush at the third edge after accept.
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.a        = 64'h1234_5678_9ABC_DEF0;
        bus.b        = 64'h7F00_0000_0000_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        saw_valid = bus.out_valid;
        repeat (2) begin
            @(posedge clk); #1;
            saw_valid = saw_valid | bus.out_valid;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush", "in_ready", 64'(bus.in_ready), 64'd1);
        repeat (12) begin
            saw_valid = saw_valid | bus.out_valid;
            @(posedge clk); #1;
        end
        check("flush", "no_valid", 64'(saw_valid), 64'd0);
        $display("TXN flush aborted MUL");
        run_op("flush_next", 3'd0, 64'd7, 64'd6, 0, obs);
        check("flush_next", "c_plan", obs, 64'd42);

        // Asynchronous reset in the middle of BUSY.
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.a        = 64'h0F0F_0F0F_0F0F_0F0F;
        bus.b        = 64'h7000_0000_0000_0003;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", "out_valid", 64'(bus.out_valid), 64'd0);
        check("async_reset", "c", bus.c, 64'd0);
        check("async_reset", "in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("async_reset", "valid_after", 64'(bus.out_valid), 64'd0);
        $display("TXN async_reset mid-BUSY");

        run_op("illegal", 3'd7, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, obs);
        check("illegal", "c_plan", obs, 64'd0);

        for (int n = 0; n < 60; n++) begin
            r   = $urandom_range(0, 19);
            rop = (r < 17) ? 3'(r % 5) : 3'(r - 12);
            run_op("random", rop, rand_operand(), rand_operand(), $urandom_range(0, 3), obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
